// File: rtl/data_memory_responder_if.sv
// Cpu-to-data-memory request/response bundle.
// The master side is the Cpu; the slave side is the memory responder.
interface data_memory_responder_if;
  logic        MemReq;
  logic        MemWE;
  logic [2:0]  MemSize;
  logic [31:0] dataMemoryAdress;
  logic [31:0] dataMemoryIn;
  logic [31:0] dataMemoryOut;
  logic        MemReady;
  logic        MemFault;
  logic        MemBusy;

  modport master (
    output MemReq,
    output MemWE,
    output MemSize,
    output dataMemoryAdress,
    output dataMemoryIn,
    input  dataMemoryOut,
    input  MemReady,
    input  MemFault,
    input  MemBusy
  );

  modport slave (
    input  MemReq,
    input  MemWE,
    input  MemSize,
    input  dataMemoryAdress,
    input  dataMemoryIn,
    output dataMemoryOut,
    output MemReady,
    output MemFault,
    output MemBusy
  );
endinterface

// File: rtl/data_memory_responder.sv
// Wait-state data memory with byte-lane loads/stores, little-endian.
// Define DMEM_STATS_EN to add load/store/fault counters.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  data_memory_responder_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] loadCount,
  output logic [31:0] storeCount,
  output logic [15:0] faultCount
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic          we;
    logic [2:0]    size;
    logic [AW+1:0] addr;
    logic [31:0]   data;
  } req_t;

  state_t      state;
  req_t        req;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          isByte;
  logic          isHalf;
  logic          isWord;
  logic          sgn;
  logic          legal;
  logic          fault;
  logic [3:0]    mask;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [31:0]   rdata;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic          wrEn;

  logic unusedAddr;
  assign unusedAddr = ^bus.dataMemoryAdress[31:AW+2];

  always_comb begin
    idx    = req.addr[AW+1:2];
    lane   = req.addr[1:0];
    isByte = (req.size[1:0] == 2'b00);
    isHalf = (req.size[1:0] == 2'b01);
    isWord = (req.size == 3'b010);
    sgn    = !req.size[2];
    if (req.we)
      legal = (req.size[2] == 1'b0) &&
              (req.size[1:0] != 2'b11);
    else
      legal = (req.size[1:0] != 2'b11) &&
              (req.size != 3'b110);
    fault = !legal ||
            (isHalf && lane[0]) ||
            (isWord && (lane != 2'b00));
    rword = mem[idx];
    rbyte = 8'(rword >> {lane, 3'b000});
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    mask  = 4'b0000;
    wdata = 32'h0;
    rdata = 32'h0;
    unique case (1'b1)
      isWord: begin
        mask  = 4'b1111;
        wdata = req.data;
        rdata = rword;
      end
      isHalf: begin
        mask  = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{req.data[15:0]}};
        rdata = {{16{sgn & rhalf[15]}}, rhalf};
      end
      isByte: begin
        mask  = 4'b0001 << lane;
        wdata = {4{req.data[7:0]}};
        rdata = {{24{sgn & rbyte[7]}}, rbyte};
      end
      default: begin
        mask  = 4'b0000;
        wdata = 32'h0;
        rdata = 32'h0;
      end
    endcase
  end

  // State is reset asynchronously, so a reset before
  // the ACCESS edge suppresses the pending write.
  assign wrEn = (state == ACCESS) && req.we && !fault;

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < 4; i++)
        if (mask[i])
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      req               <= '0;
      cnt               <= 4'd0;
      bus.dataMemoryOut <= 32'h0;
      bus.MemReady      <= 1'b0;
      bus.MemFault      <= 1'b0;
      bus.MemBusy       <= 1'b0;
    end else begin
      bus.MemReady <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.MemReq) begin
            req.we      <= bus.MemWE;
            req.size    <= bus.MemSize;
            req.addr    <= bus.dataMemoryAdress[AW+1:0];
            req.data    <= bus.dataMemoryIn;
            cnt         <= 4'(WAIT_CYCLES);
            bus.MemBusy <= 1'b1;
            state       <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1)
            state <= ACCESS;
        end
        ACCESS: begin
          bus.dataMemoryOut <= (fault || req.we) ? 32'h0 : rdata;
          bus.MemFault      <= fault;
          bus.MemReady      <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          bus.MemBusy <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loadCount  <= 32'h0;
      storeCount <= 32'h0;
      faultCount <= 16'h0;
    end else if (state == RESP) begin
      if (bus.MemFault) begin
        if (faultCount != 16'hFFFF)
          faultCount <= faultCount + 16'd1;
      end else if (req.we) begin
        storeCount <= storeCount + 32'd1;
      end else begin
        loadCount <= loadCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder against a byte-array memory model.
// Counter ports are checked when DMEM_STATS_EN is defined.
module tb_data_memory_responder;
  localparam int W     = 2;
  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_responder_if bus();

`ifdef DMEM_STATS_EN
  logic [31:0] loadCount;
  logic [31:0] storeCount;
  logic [15:0] faultCount;
`endif

  data_memory_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
`ifdef DMEM_STATS_EN
    ,
    .loadCount(loadCount),
    .storeCount(storeCount),
    .faultCount(faultCount)
`endif
  );

  int checks = 0;
  int errors = 0;
  int expLoads = 0;
  int expStores = 0;
  int expFaults = 0;
  logic [7:0] bmem [BYTES];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic void model(input logic we,
                                input logic [2:0] sz,
                                input logic [31:0] a,
                                input logic [31:0] d,
                                output logic [31:0] out,
                                output logic flt);
    int n;
    bit sgn;
    int base;
    logic [31:0] v;
    base = int'(a & (BYTES - 1));
    n = 0;
    sgn = 0;
    case (sz)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: n = 4;
      3'd4: if (!we) n = 1;
      3'd5: if (!we) n = 2;
      default: n = 0;
    endcase
    flt = (n == 0) ? 1'b1 : ((base % n) != 0);
    out = 32'h0;
    if (flt) return;
    if (we) begin
      for (int i = 0; i < n; i++)
        bmem[base + i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++)
        v = v | (32'(bmem[base + i]) << (8 * i));
      if (sgn && n < 4 && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8 * n));
      out = v;
    end
  endfunction

  task automatic drive(input logic we,
                       input logic [2:0] sz,
                       input logic [31:0] a,
                       input logic [31:0] d);
    bus.MemReq = 1'b1;
    bus.MemWE = we;
    bus.MemSize = sz;
    bus.dataMemoryAdress = a;
    bus.dataMemoryIn = d;
  endtask

  task automatic txn(input logic we,
                     input logic [2:0] sz,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input string tag,
                     output logic [31:0] got);
    logic [31:0] eo;
    logic ef;
    int lat;
    model(we, sz, a, d, eo, ef);
    drive(we, sz, a, d);
    @(posedge clk);
    @(negedge clk);
    bus.MemReq = 1'b0;
    lat = 1;
    while (bus.MemReady !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = bus.dataMemoryOut;
    check({tag, " latency"}, lat, W + 2);
    check({tag, " data"}, bus.dataMemoryOut, eo);
    check({tag, " fault"}, 32'(bus.MemFault), 32'(ef));
    check({tag, " busy"}, 32'(bus.MemBusy), 32'd1);
    if (ef) expFaults++;
    else if (we) expStores++;
    else expLoads++;
    @(negedge clk);
    check({tag, " hold"}, bus.dataMemoryOut, eo);
    check({tag, " pulse"}, 32'(bus.MemReady), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] eo;
    logic ef;
    logic [31:0] word10;
    int pulses;
    int lat;

    bus.MemReq = 1'b0;
    bus.MemWE = 1'b0;
    bus.MemSize = 3'd0;
    bus.dataMemoryAdress = 32'h0;
    bus.dataMemoryIn = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ready", 32'(bus.MemReady), 32'd0);
    check("reset busy", 32'(bus.MemBusy), 32'd0);
    check("reset fault", 32'(bus.MemFault), 32'd0);
    check("reset data", bus.dataMemoryOut, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      txn(1'b1, 3'd2, 32'(i * 4), $urandom, "init", got);

    txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10", got);
    txn(1'b0, 3'd2, 32'h10, 32'h0, "lw10", got);
    check("lw10 value", got, 32'hDEADBEEF);
    txn(1'b1, 3'd0, 32'h11, 32'h80, "sb11", got);
    check("store out zero", got, 32'h0);
    txn(1'b0, 3'd2, 32'h10, 32'h0, "lw10b", got);
    check("lw10b value", got, 32'hDEAD80EF);
    txn(1'b0, 3'd0, 32'h11, 32'h0, "lb11", got);
    check("lb11 value", got, 32'hFFFFFF80);
    txn(1'b0, 3'd4, 32'h11, 32'h0, "lbu11", got);
    check("lbu11 value", got, 32'h00000080);
    txn(1'b1, 3'd1, 32'h12, 32'h1234, "sh12", got);
    txn(1'b0, 3'd1, 32'h12, 32'h0, "lh12", got);
    check("lh12 value", got, 32'h00001234);
    txn(1'b0, 3'd2, 32'h10, 32'h0, "lw10c", word10);
    txn(1'b1, 3'd1, 32'h13, 32'hBEEF, "sh13", got);
    txn(1'b0, 3'd2, 32'h10, 32'h0, "lw10d", got);
    check("sh13 no write", got, word10);
    txn(1'b1, 3'd2, 32'h1000, 32'hA5A5A5A5, "sw1000", got);
    txn(1'b0, 3'd2, 32'h0, 32'h0, "lw0 wrap", got);
    check("wrap value", got, 32'hA5A5A5A5);
    txn(1'b0, 3'd2, 32'h2, 32'h0, "lw misalign", got);
    txn(1'b0, 3'd3, 32'h4, 32'h0, "bad load size", got);
    txn(1'b1, 3'd4, 32'h4, 32'h5A, "bad store size", got);

    drive(1'b1, 3'd2, 32'h20, 32'h11111111);
    @(posedge clk);
    @(negedge clk);
    bus.MemReq = 1'b0;
    check("rst pre busy", 32'(bus.MemBusy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst ready", 32'(bus.MemReady), 32'd0);
    check("rst busy", 32'(bus.MemBusy), 32'd0);
    check("rst data", bus.dataMemoryOut, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst busy held", 32'(bus.MemBusy), 32'd0);
    rst_n = 1'b1;
    expLoads = 0;
    expStores = 0;
    expFaults = 0;
    @(negedge clk);
    txn(1'b0, 3'd2, 32'h20, 32'h0, "lw20 after rst", got);

    model(1'b0, 3'd2, 32'h10, 32'h0, eo, ef);
    drive(1'b0, 3'd2, 32'h10, 32'h0);
    @(posedge clk);
    pulses = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      pulses += int'(bus.MemReady);
    end
    check("held req pulses", 32'(pulses), 32'd1);
    check("held req idle", 32'(bus.MemBusy), 32'd0);
    check("held req data", bus.dataMemoryOut, eo);
    @(negedge clk);
    check("held req reaccept", 32'(bus.MemBusy), 32'd1);
    bus.MemReq = 1'b0;
    lat = 1;
    while (bus.MemReady !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("held req 2nd lat", 32'(lat), 32'(W + 2));
    check("held req 2nd data", bus.dataMemoryOut, eo);
    expLoads += 2;
    @(negedge clk);

    for (int i = 0; i < 60; i++)
      txn(1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)),
          $urandom & 32'hFFFFF03F,
          $urandom, "random", got);

`ifdef DMEM_STATS_EN
    check("loadCount", loadCount, 32'(expLoads));
    check("storeCount", storeCount, 32'(expStores));
    check("faultCount", 32'(faultCount), 32'(expFaults));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
